// File: rtl/mmss_lap_counter.sv
// Purpose : minute/second BCD stopwatch core with lap snapshot, counting 00:00..MAX_MIN:MAX_SEC.
// Latency : count and display update on the sampling _1Hzclk edge; lap freeze/unfreeze one edge after lap_state changes.
// Backpressure: none; stop=1 pauses counting, clr_n=0 clears synchronously and overrides stop and lap.
//
// Ports:
//   _1Hzclk   count clock, rising edge
//   init_rst  asynchronous active-low reset
//   clr_n     synchronous active-low clear (live count, lap snapshot, lap hold)
//   stop      1 = paused, 0 = counting
//   lap_state 1 = display frozen on the lap snapshot
//   min_tens/min_ones/sec_tens/sec_ones  displayed BCD digits
//   run       registered, high while in RUN
//   full      registered saturation / wrap flag
//
// Build option: define MMSS_WRAP_EN to wrap to 00:00 at the top count (full pulses
// for one cycle). Without it the count saturates in FULL until clr_n or init_rst.
module mmss_lap_counter #(
  parameter int MAX_MIN = 59,
  parameter int MAX_SEC = 59
) (
  input  logic       _1Hzclk,
  input  logic       init_rst,
  input  logic       clr_n,
  input  logic       stop,
  input  logic       lap_state,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       run,
  output logic       full
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_FULL  = 2'd3
  } state_t;

  localparam logic [3:0] TOP_MT = 4'(MAX_MIN / 10);
  localparam logic [3:0] TOP_MO = 4'(MAX_MIN % 10);
  localparam logic [3:0] TOP_ST = 4'(MAX_SEC / 10);
  localparam logic [3:0] TOP_SO = 4'(MAX_SEC % 10);

  state_t     state, state_nxt;

  // live count digits
  logic [3:0] mt, mo, st, so;
  // lap snapshot digits
  logic [3:0] lap_mt, lap_mo, lap_st, lap_so;
  logic       lap_hold;

  logic       at_top;
  logic       inc_en;    // normal BCD increment this edge
  logic       wrap_evt;  // top count rolls back to 00:00 this edge
  logic       full_nxt;

  assign at_top = (mt == TOP_MT) && (mo == TOP_MO) && (st == TOP_ST) && (so == TOP_SO);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge _1Hzclk or negedge init_rst) begin
    if (!init_rst) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    inc_en    = 1'b0;
    wrap_evt  = 1'b0;
    full_nxt  = 1'b0;
    if (!clr_n) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_PAUSE, S_RUN: begin
          if (stop) begin
            // IDLE stays IDLE while stopped; a running count pauses
            if (state == S_RUN) state_nxt = S_PAUSE;
          end else if (at_top) begin
`ifdef MMSS_WRAP_EN
            state_nxt = S_RUN;
            wrap_evt  = 1'b1;
            full_nxt  = 1'b1;
`else
            state_nxt = S_FULL;
            full_nxt  = 1'b1;
`endif
          end else begin
            state_nxt = S_RUN;
            inc_en    = 1'b1;
          end
        end
        S_FULL: begin
          // saturated: stop is ignored, only clear or reset leaves
          state_nxt = S_FULL;
          full_nxt  = 1'b1;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge _1Hzclk or negedge init_rst) begin
    if (!init_rst) begin
      run  <= 1'b0;
      full <= 1'b0;
    end else begin
      run  <= (state_nxt == S_RUN);
      full <= full_nxt;
    end
  end

  // ---------------------------------------------------------------- live count
  always_ff @(posedge _1Hzclk or negedge init_rst) begin
    if (!init_rst) begin
      mt <= 4'd0; mo <= 4'd0; st <= 4'd0; so <= 4'd0;
    end else if (!clr_n || wrap_evt) begin
      mt <= 4'd0; mo <= 4'd0; st <= 4'd0; so <= 4'd0;
    end else if (inc_en) begin
      // ripple carry through the four BCD digits; each digit only ever
      // takes legal values (ones 0-9, tens 0-5)
      if (so != 4'd9) begin
        so <= so + 4'd1;
      end else begin
        so <= 4'd0;
        if (st != 4'd5) begin
          st <= st + 4'd1;
        end else begin
          st <= 4'd0;
          if (mo != 4'd9) begin
            mo <= mo + 4'd1;
          end else begin
            mo <= 4'd0;
            if (mt != 4'd5) mt <= mt + 4'd1;
            else            mt <= 4'd0;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- lap
  always_ff @(posedge _1Hzclk or negedge init_rst) begin
    if (!init_rst) begin
      lap_hold <= 1'b0;
      lap_mt <= 4'd0; lap_mo <= 4'd0; lap_st <= 4'd0; lap_so <= 4'd0;
    end else if (!clr_n) begin
      lap_hold <= 1'b0;
      lap_mt <= 4'd0; lap_mo <= 4'd0; lap_st <= 4'd0; lap_so <= 4'd0;
    end else begin
      lap_hold <= lap_state;
      // capture the pre-increment count on the lap rising edge
      if (lap_state && !lap_hold) begin
        lap_mt <= mt; lap_mo <= mo; lap_st <= st; lap_so <= so;
      end
    end
  end

  // ---------------------------------------------------------------- display
  always_comb begin
    if (lap_hold) begin
      min_tens = lap_mt; min_ones = lap_mo; sec_tens = lap_st; sec_ones = lap_so;
    end else begin
      min_tens = mt;     min_ones = mo;     sec_tens = st;     sec_ones = so;
    end
  end

endmodule

// File: doc/mmss_lap_counter.md
# mmss_lap_counter

Minute/second BCD stopwatch core for the lab05 stopwatch, downstream of the start/stop/lap control logic. It advances a 00:00–59:59 count once per `_1Hzclk` edge while running and holds a lap snapshot while lap mode is active. It presents four BCD digits to the seven-segment scan stage.

## Interface
Parameters:
- MAX_MIN, 59, highest minute value before wrap/saturation (BCD-encodable, 0–59)
- MAX_SEC, 59, highest second value (fixed by BCD seconds, 0–59)

Ports:
- _1Hzclk  in  1  count clock; all state changes on rising edge
- init_rst  in  1  reset, asynchronous, active-low
- clr_n  in  1  synchronous clear, active-low; driven by control when lap pressed while stopped
- stop  in  1  1 = paused, 0 = counting
- lap_state  in  1  1 = display frozen on lap snapshot
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  displayed BCD digits
- run  out  1  1 while FSM in RUN
- full  out  1  saturation flag (see Configuration)

## Operation
- FSM states: IDLE (count 00:00, not counting), RUN, PAUSE, FULL.
- IDLE -> RUN when stop=0; RUN -> PAUSE when stop=1; PAUSE -> RUN when stop=0.
- RUN at 59:59 (MAX_MIN:MAX_SEC) with stop=0: behaviour per Configuration.
- Any state -> IDLE when clr_n=0. Clear clears live count and lap snapshot to 00:00 and lap_hold to 0. clr_n has priority over stop and lap.
- Counting in RUN: sec_ones 0–9, carry to sec_tens 0–5, carry to min_ones 0–9, carry to min_tens 0–5. Every digit stays legal BCD at all times; no value >9 or tens >5 is ever visible.
- lap_hold: registered copy of lap_state.
- Lap capture: on an edge where lap_state=1 and lap_hold=0, lap_reg <= live count. This is the pre-increment value at that edge.
- Display mux (combinational from registers): lap_hold ? lap_reg : live count.
- Lap has no effect on counting; the live count keeps advancing while the display is frozen.
- Lap rising in PAUSE or IDLE still captures; control normally gates this.

## Timing
- Reset (init_rst=0) values: state IDLE, live count 00:00, lap_reg 00:00, lap_hold 0, all digit outputs 0, run 0, full 0. Reset takes effect immediately, including mid-count.
- Count increments on the first edge where stop=0 is sampled. The displayed value changes on that same edge when lap_hold=0.
- stop=1 sampled at an edge: no increment on that edge.
- Freeze latency: display freezes 1 edge after lap_state rises. It unfreezes 1 edge after lap_state falls and shows the current live count.
- Simultaneous clr_n=0 and lap rise: clear wins; lap_reg = 00:00.
- run and full are registered from state; no combinational paths from inputs to outputs except none. Digits come from registers only.

## Configuration
- Macro: `MMSS_WRAP_EN`.
- Defined: on the 59:59 -> next increment, the count wraps to 00:00 and stays in RUN. full pulses high for exactly one cycle on the wrap edge.
- Undefined: the count holds at 59:59 and the FSM enters FULL, with full=1 and run=0. FULL ignores stop; it exits only via clr_n=0 or init_rst.

## Test plan
- Reset: init_rst low 2 ns then high, with stop=1 -> digits 0,0,0,0; run=0; full=0; 5 edges later still 00:00.
- Run: stop=0 for 75 edges -> display 01:15 (1,0? no: min_tens 0, min_ones 1, sec_tens 1, sec_ones 5); run=1. Check the 00:09->00:10 and 00:59->01:00 carries.
- Pause/resume: run 10 edges, stop=1 for 4 edges, stop=0 for 3 edges -> 00:13; no change during the pause.
- Lap: run to 00:20, raise lap_state -> display stays 00:20 while live count advances. After 12 more edges, drop lap_state -> display shows 00:33 one edge later.
- Clear: stop=1 at 02:07, pulse clr_n low for 1 edge -> 00:00, IDLE, lap_reg 00:00.
- Boundary: preload to 59:58 by counting, then run 2 edges. With `MMSS_WRAP_EN` -> 00:00 and a 1-cycle full pulse. Without it -> held at 59:59, full=1, run=0, and clr_n recovers to 00:00.
